// File: rtl/mips_mdu_alu.sv
// W-bit MIPS execute unit: single-cycle ALU with a registered result, plus an iterative
// unsigned multiply/divide unit with HI/LO registers and a start/busy/done handshake.
module mips_mdu_alu #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         overflow,
    output logic         div_by_zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpAnd   = 4'b0010;
    localparam logic [3:0] OpOr    = 4'b0011;
    localparam logic [3:0] OpNor   = 4'b0100;
    localparam logic [3:0] OpSlt   = 4'b0101;
    localparam logic [3:0] OpSltu  = 4'b0110;
    localparam logic [3:0] OpXor   = 4'b0111;
    localparam logic [3:0] OpMultu = 4'b1000;
    localparam logic [3:0] OpDivu  = 4'b1001;
    localparam logic [3:0] OpMfhi  = 4'b1010;
    localparam logic [3:0] OpMflo  = 4'b1011;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  work_hi_q, work_hi_d, work_lo_q, work_lo_d, opnd_q, opnd_d;
    logic [W-1:0]  result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic          zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;

    logic [W-1:0] sum, diff, alu_res;
    logic         alu_ovf;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OpSub: begin
                alu_res = diff;
                alu_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OpAnd:  alu_res = a & b;
            OpOr:   alu_res = a | b;
            OpNor:  alu_res = ~(a | b);
            OpSlt:  alu_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            OpSltu: alu_res = {{(W-1){1'b0}}, a < b};
            OpXor:  alu_res = a ^ b;
            OpMfhi: alu_res = hi_q;
            OpMflo: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // MUL: work_hi accumulates, work_lo holds the multiplier and shifts in product bits.
    // DIV: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
    logic [W:0]   mul_sum, div_shift, div_trial;
    logic [W-1:0] iter_hi, iter_lo;

    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {work_hi_q, work_lo_q[W-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};

    always_comb begin
        if (state_q == StMul) begin
            iter_hi = mul_sum[W:1];
            iter_lo = {mul_sum[0], work_lo_q[W-1:1]};
        end else if (!div_trial[W]) begin
            iter_hi = div_trial[W-1:0];
            iter_lo = {work_lo_q[W-2:0], 1'b1};
        end else begin
            iter_hi = div_shift[W-1:0];
            iter_lo = {work_lo_q[W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opnd_d    = opnd_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (state_q == StMul || state_q == StDiv) begin
            work_hi_d = iter_hi;
            work_lo_d = iter_lo;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d  = StDone;
                hi_d     = iter_hi;
                lo_d     = iter_lo;
                result_d = iter_lo;
                zero_d   = (iter_lo == '0);
            end
        end else if (start) begin
            ovf_d = 1'b0;
            dbz_d = 1'b0;
            if (op == OpMultu) begin
                state_d   = StMul;
                cnt_d     = CW'(W);
                work_hi_d = '0;
                work_lo_d = b;
                opnd_d    = a;
            end else if (op == OpDivu && b == '0) begin
                state_d  = StDone;
                hi_d     = a;
                lo_d     = '1;
                result_d = '1;
                zero_d   = 1'b0;
                dbz_d    = 1'b1;
            end else if (op == OpDivu) begin
                state_d   = StDiv;
                cnt_d     = CW'(W);
                work_hi_d = '0;
                work_lo_d = a;
                opnd_d    = b;
            end else begin
                state_d  = StDone;
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                ovf_d    = alu_ovf;
            end
        end else if (state_q == StDone) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q == StMul) || (state_q == StDiv);
    assign done        = (state_q == StDone);
    assign result      = result_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/mips_mdu_alu.md
Name: mips_mdu_alu

Overview:
- Parametrised W-bit MIPS execute unit; replaces the fixed 8-bit combinational ALU in the datapath.
- Performs single-cycle logic and arithmetic ops with a registered result.
- Adds an iterative unsigned multiply/divide unit with HI/LO registers and a start/busy/done handshake.
- The control unit stalls the pipeline while `busy` is high.

Parameters:
- W, 8, operand/result width in bits (min 4).
- CW, $clog2(W)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy==0.
- op  in  4  operation code (encoding below).
- a  in  W  operand A (rs).
- b  in  W  operand B (rt/imm).
- busy  out  1  high while a multiply/divide iterates.
- done  out  1  one-cycle pulse: result/flags valid.
- result  out  W  registered result.
- zero  out  1  result==0, registered alongside result.
- overflow  out  1  signed overflow for ADD/SUB, else 0.
- div_by_zero  out  1  last accepted op was DIVU with b==0.
- hi  out  W  HI register.
- lo  out  W  LO register.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - busy, done, result, zero, overflow, div_by_zero, hi, lo, counter all 0.
  - Reset mid-multiply/divide aborts the operation; no done pulse follows.
- Op encoding (result shown per op):
  - 0000 ADD: a+b.
  - 0001 SUB: a-b.
  - 0010 AND: a&b.
  - 0011 OR: a|b.
  - 0100 NOR: ~(a|b).
  - 0101 SLT: signed a<b, result 1/0.
  - 0110 SLTU: unsigned a<b.
  - 0111 XOR: a^b.
  - 1000 MULTU: {hi,lo} = a*b, 2W-bit unsigned product; result=lo.
  - 1001 DIVU: lo=a/b, hi=a%b; result=lo.
  - 1010 MFHI: result=hi.
  - 1011 MFLO: result=lo.
  - 11xx: reserved; result=0, done pulses, hi/lo unchanged.
- Arithmetic: ADD/SUB wrap mod 2^W. overflow = signed overflow of the W-bit op.
- States: IDLE, MUL, DIV, DONE.
- Acceptance: start is sampled when busy==0 (IDLE or DONE).
  - a, b and op are captured into internal registers at acceptance.
  - Inputs are ignored afterwards until the next acceptance.
  - start while busy==1 is ignored; no queuing.
- Single-cycle ops: accepted at edge N -> DONE at N+1. result, zero, overflow update and done=1 at N+1.
- MULTU: shift-add, one multiplier bit per cycle.
  - Accepted at edge N: busy=1 for cycles N+1 .. N+W.
  - hi/lo and result update together with done=1 at N+W+1.
  - busy=0 in DONE.
- DIVU (b!=0): restoring division, one quotient bit per cycle. Same timing as MULTU (W busy cycles, done at N+W+1).
- DIVU (b==0): no iteration; DONE at N+1 with hi=a, lo={W{1'b1}}, result=lo, div_by_zero=1.
- div_by_zero and overflow are cleared on the next accepted op unless that op sets them again.
- hi/lo change only at completion of MULTU/DIVU. Intermediate values live in private shift registers, so MFHI/MFLO never see partial products.
- DONE state:
  - With no start: go to IDLE at the next edge.
  - With start: accept the new op directly (back-to-back throughput of 1 single-cycle op per cycle).
- done is high only in the DONE state.
- result, zero, overflow and div_by_zero hold their values through IDLE until the next completion.
- Counter: loads W at acceptance, decrements each MUL/DIV cycle, transitions to DONE when it reaches 0.

Test Plan (W=8):
- Reset: assert reset_n=0 mid-MULTU (cycle 3 of busy) -> busy=0, hi=lo=result=0 immediately; no done pulse after release.
- ALU ops: ADD 0x7F+0x01 -> result=0x80, overflow=1, done 1 cycle later. SUB 0x05-0x05 -> result=0, zero=1. SLT 0xFF,0x01 -> 1. SLTU 0xFF,0x01 -> 0.
- MULTU 0xFF*0xFF:
  - busy exactly 8 cycles, done at cycle 9.
  - hi=0xFE, lo=0x01, result=0x01.
  - A following MFHI returns 0xFE one cycle later.
- DIVU 200/7 -> lo=28 (0x1C), hi=4, done at cycle 9. DIVU 0x2A/0 -> done at cycle 1, hi=0x2A, lo=0xFF, div_by_zero=1.
- Handshake: pulse start with ADD during MULTU busy -> ignored; hi/lo/result reflect only MULTU. start asserted in DONE is accepted back-to-back.
- Random regression: 1000 random op/a/b vs. reference model checking result, hi, lo, flags and done latency (1 or W+1).
